// File: rtl/pf_vscroll_ctrl.sv
// pf_vscroll_ctrl: drive side of the playfield vertical-scroll counter chain.
//
// The CPU writes a double-buffered scroll value. It is parallel-loaded into the external
// cascaded up/down counters once per frame, at vblank start. During active display the
// block issues one count-enable pulse per scanline. The chain's terminal count is
// watched so that a vertical wrap can be flagged.
//
// Optional build macro VSCROLL_MIDFRAME_EN: when it is defined, a value still pending
// during active display is loaded on the next hblank rise instead of a count step. This
// gives a split-screen scroll.
//
// Ports:
//   clk, rst_b     clock (posedge) and asynchronous active-low reset
//   cpu_we         CPU write strobe
//   cpu_sel_hi     0: scroll[7:0]; 1: scroll[WIDTH-1:8] plus direction in cpu_data[7]
//   cpu_data       CPU write data
//   vblank/hblank  video timing levels
//   tc_in          terminal count of the most-significant counter stage
//   scroll_d       parallel load value
//   scroll_load_b  active-low parallel load, held LOAD_CYC cycles
//   scroll_ce_b    active-low count enable, one cycle per scanline
//   scroll_du      count direction (0 up, 1 down)
//   pending        shadow written but not yet loaded
//   wrap_pulse     one-cycle flag after a count step taken with tc_in high
module pf_vscroll_ctrl #(
  parameter int unsigned WIDTH    = 9,
  parameter int unsigned LOAD_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             cpu_we,
  input  logic             cpu_sel_hi,
  input  logic [7:0]       cpu_data,
  input  logic             vblank,
  input  logic             hblank,
  input  logic             tc_in,
  output logic [WIDTH-1:0] scroll_d,
  output logic             scroll_load_b,
  output logic             scroll_ce_b,
  output logic             scroll_du,
  output logic             pending,
  output logic             wrap_pulse
);

  localparam int unsigned CntW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

  typedef enum logic [1:0] {S_VBL, S_LOAD, S_ACT} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_shadow, w_shadow_d;
  logic             r_dir, w_dir_d;
  logic             r_pending, w_pending_d;
  logic             r_vbl_q, r_vbl_p, r_hbl_q, r_hbl_p;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic             r_ret_act, w_ret_act_d;
  logic [WIDTH-1:0] r_scroll_d, w_scroll_d_d;
  logic             r_load_b, w_load_b_d;
  logic             r_ce_b, w_ce_b_d;
  logic             r_du, w_du_d;
  logic             r_wrap, w_wrap_d;

  logic             w_vbl_rise, w_hbl_rise, w_pend_any, w_load_go;
  logic [15:0]      w_sh16;

  assign w_vbl_rise = r_vbl_q & ~r_vbl_p;
  assign w_hbl_rise = r_hbl_q & ~r_hbl_p;
  // A write landing in the same cycle as a load decision is merged into that load.
  assign w_pend_any = r_pending | cpu_we;

  // Apply the CPU write on a 16-bit view so that bits above WIDTH simply fall away.
  always_comb begin
    w_sh16  = 16'(r_shadow);
    w_dir_d = r_dir;
    if (cpu_we) begin
      if (cpu_sel_hi) begin
        w_sh16[15:8] = cpu_data;
        w_dir_d      = cpu_data[7];
      end else begin
        w_sh16[7:0] = cpu_data;
      end
    end
    w_shadow_d = w_sh16[WIDTH-1:0];
  end

  always_comb begin
    w_state_d    = r_state;
    w_scroll_d_d = r_scroll_d;
    w_load_b_d   = 1'b1;
    w_ce_b_d     = 1'b1;
    w_du_d       = r_du;
    w_cnt_d      = r_cnt;
    w_ret_act_d  = r_ret_act;
    w_pending_d  = w_pend_any;
    w_load_go    = 1'b0;
    w_wrap_d     = ~r_ce_b & tc_in;

    unique case (r_state)
      S_VBL: begin
        if (w_vbl_rise && w_pend_any) begin
          w_load_go   = 1'b1;
          w_ret_act_d = 1'b0;
        end else if (!r_vbl_q) begin
          w_state_d = S_ACT;
        end
      end
      S_LOAD: begin
        if (r_cnt != '0) begin
          w_load_b_d = 1'b0;
          w_cnt_d    = r_cnt - 1'b1;
        end else begin
          w_state_d = r_ret_act ? S_ACT : S_VBL;
        end
      end
      S_ACT: begin
        if (w_vbl_rise) begin
          w_ret_act_d = 1'b0;
          if (w_pend_any) w_load_go = 1'b1;
          else            w_state_d = S_VBL;
        end
`ifdef VSCROLL_MIDFRAME_EN
        else if (w_hbl_rise && w_pend_any) begin
          w_load_go   = 1'b1;
          w_ret_act_d = 1'b1;
        end
`endif
        else if (w_hbl_rise) begin
          w_ce_b_d = 1'b0;
        end
      end
      default: w_state_d = S_VBL;
    endcase

    if (w_load_go) begin
      w_state_d    = S_LOAD;
      w_load_b_d   = 1'b0;
      w_cnt_d      = CntW'(LOAD_CYC - 1);
      w_scroll_d_d = w_shadow_d;
      w_pending_d  = 1'b0;
    end

    // Direction only moves on a state change or as a ce pulse ends. The next pulse is at
    // least one cycle away, so scroll_du is settled before and during every pulse.
    if ((w_state_d != r_state) || !r_ce_b) w_du_d = r_dir;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= S_VBL;
      r_shadow   <= '0;
      r_dir      <= 1'b0;
      r_pending  <= 1'b0;
      r_vbl_q    <= 1'b0;
      r_vbl_p    <= 1'b0;
      r_hbl_q    <= 1'b0;
      r_hbl_p    <= 1'b0;
      r_cnt      <= '0;
      r_ret_act  <= 1'b0;
      r_scroll_d <= '0;
      r_load_b   <= 1'b1;
      r_ce_b     <= 1'b1;
      r_du       <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_shadow   <= w_shadow_d;
      r_dir      <= w_dir_d;
      r_pending  <= w_pending_d;
      r_vbl_q    <= vblank;
      r_vbl_p    <= r_vbl_q;
      r_hbl_q    <= hblank;
      r_hbl_p    <= r_hbl_q;
      r_cnt      <= w_cnt_d;
      r_ret_act  <= w_ret_act_d;
      r_scroll_d <= w_scroll_d_d;
      r_load_b   <= w_load_b_d;
      r_ce_b     <= w_ce_b_d;
      r_du       <= w_du_d;
      r_wrap     <= w_wrap_d;
    end
  end

  assign scroll_d      = r_scroll_d;
  assign scroll_load_b = r_load_b;
  assign scroll_ce_b   = r_ce_b;
  assign scroll_du     = r_du;
  assign pending       = r_pending;
  assign wrap_pulse    = r_wrap;

endmodule

// File: tb/tb_pf_vscroll_ctrl.sv
// Self-checking bench for pf_vscroll_ctrl (WIDTH=9, LOAD_CYC=2). A negedge monitor turns
// the output waveforms into transactions: load pulses (length and value), ce pulses,
// and wraps. The main thread then compares these against a frame-level model of the
// shadow register and direction bit.
module tb_pf_vscroll_ctrl;

  localparam int unsigned W  = 9;
  localparam int unsigned LC = 2;

  logic         clk = 1'b0;
  logic         rst_b, cpu_we, cpu_sel_hi, vblank, hblank, tc_in;
  logic [7:0]   cpu_data;
  logic [W-1:0] scroll_d;
  logic         scroll_load_b, scroll_ce_b, scroll_du, pending, wrap_pulse;

  pf_vscroll_ctrl #(.WIDTH(W), .LOAD_CYC(LC)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .cpu_we        (cpu_we),
    .cpu_sel_hi    (cpu_sel_hi),
    .cpu_data      (cpu_data),
    .vblank        (vblank),
    .hblank        (hblank),
    .tc_in         (tc_in),
    .scroll_d      (scroll_d),
    .scroll_load_b (scroll_load_b),
    .scroll_ce_b   (scroll_ce_b),
    .scroll_du     (scroll_du),
    .pending       (pending),
    .wrap_pulse    (wrap_pulse)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Monitor state
  int n_ce = 0, n_du1 = 0, n_tc = 0, n_wrap = 0;
  int ce_err = 0, du_err = 0, wrap_err = 0, ld_err = 0;
  int q_len[$];
  int q_val[$];
  int run = 0, run_val = 0;
  logic prev_ce = 1'b1, prev_du = 1'b0, exp_wrap = 1'b0;

  always @(negedge clk) begin
    if (!scroll_ce_b) begin
      n_ce++;
      if (scroll_du) n_du1++;
      if (tc_in) n_tc++;
      if (!prev_ce) ce_err++;
      if (scroll_du != prev_du) du_err++;
    end
    if (wrap_pulse) n_wrap++;
    if (rst_b && (wrap_pulse != exp_wrap)) wrap_err++;
    exp_wrap = !scroll_ce_b && tc_in;
    if (!scroll_load_b) begin
      if (run == 0) run_val = int'(scroll_d);
      else if (int'(scroll_d) != run_val) ld_err++;
      run++;
    end else if (run != 0) begin
      q_len.push_back(run);
      q_val.push_back(run_val);
      run = 0;
    end
    prev_ce = scroll_ce_b;
    prev_du = scroll_du;
  end

  // Reference model
  logic [8:0] m_sh = '0;
  logic       m_dir = 1'b0;
  logic       tc_rand = 1'b0, tc_fix = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      tc_in = tc_rand ? 1'($urandom_range(0, 1)) : tc_fix;
    end
  endtask

  task automatic cpu_write(input logic sel, input logic [7:0] data);
    cpu_we = 1'b1; cpu_sel_hi = sel; cpu_data = data;
    tick(1);
    cpu_we = 1'b0;
    if (sel) begin m_sh[8] = data[0]; m_dir = data[7]; end
    else m_sh[7:0] = data;
  endtask

  task automatic lines(input int n);
    repeat (n) begin
      hblank = 1'b1; tick(3);
      hblank = 1'b0; tick(5);
    end
  endtask

  task automatic vbl_start();
    vblank = 1'b1; tick(10);
  endtask

  task automatic vbl_end();
    vblank = 1'b0; tick(4);
  endtask

  task automatic check_load(input string name, input int exp_n, input int exp_val);
    check({name, " load count"}, q_len.size(), exp_n);
    if (exp_n == 1 && q_len.size() >= 1) begin
      check({name, " load len"}, q_len[0], int'(LC));
      check({name, " load val"}, q_val[0], exp_val);
    end
    q_len.delete();
    q_val.delete();
  endtask

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    int         exp_d;
    int         exp_du;
    int         nlines;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int c0, d0, t0, w0, nl, nw, dir0, found;
    logic [7:0] rd;

    vecs[0] = '{lo: 8'h34, hi: 8'h01, exp_d: 'h134, exp_du: 0, nlines: 240};
    vecs[1] = '{lo: 8'hFF, hi: 8'hFE, exp_d: 'h0FF, exp_du: 1, nlines: 5};
    vecs[2] = '{lo: 8'h00, hi: 8'h81, exp_d: 'h100, exp_du: 1, nlines: 240};
    vecs[3] = '{lo: 8'hA5, hi: 8'h7E, exp_d: 'h0A5, exp_du: 0, nlines: 3};

    rst_b = 1'b0; cpu_we = 1'b0; cpu_sel_hi = 1'b0; cpu_data = '0;
    vblank = 1'b1; hblank = 1'b0; tc_in = 1'b0;
    tick(3);
    rst_b = 1'b1;
    tick(3);
    check("reset load_b", int'(scroll_load_b), 1);
    check("reset ce_b", int'(scroll_ce_b), 1);
    check("reset du", int'(scroll_du), 0);
    check("reset scroll_d", int'(scroll_d), 0);
    check("reset pending", int'(pending), 0);
    check("reset wrap", int'(wrap_pulse), 0);

    // A vblank start with nothing written must not load.
    vbl_end();
    vbl_start();
    check_load("no write", 0, 0);

    vbl_end();
    foreach (vecs[i]) begin
      cpu_write(1'b0, vecs[i].lo);
      cpu_write(1'b1, vecs[i].hi);
      check("vec pending set", int'(pending), 1);
      vbl_start();
      check_load("vec", 1, vecs[i].exp_d);
      check("vec pending clr", int'(pending), 0);
      vbl_end();
      c0 = n_ce; d0 = n_du1;
      lines(vecs[i].nlines);
      check("vec ce count", n_ce - c0, vecs[i].nlines);
      check("vec du ones", n_du1 - d0, vecs[i].exp_du * vecs[i].nlines);
    end

    // tc_in high: wrap after every step, none while no step is taken
    tc_fix = 1'b1;
    w0 = n_wrap;
    lines(4);
    check("wrap on steps", n_wrap - w0, 4);
    w0 = n_wrap;
    vbl_start();
    check("no wrap idle", n_wrap - w0, 0);
    tc_fix = 1'b0;
    tick(1);

    // Reset while the load is in progress
    vbl_end();
    cpu_write(1'b0, 8'hAB);
    cpu_write(1'b1, 8'h01);
    vblank = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      tick(1);
      if (!scroll_load_b) found = 1;
    end
    check("load seen before reset", found, 1);
    rst_b = 1'b0;
    #1;
    check("rst load_b", int'(scroll_load_b), 1);
    check("rst scroll_d", int'(scroll_d), 0);
    tick(2);
    rst_b = 1'b1;
    m_sh = '0; m_dir = 1'b0;
    tick(2);
    q_len.delete(); q_val.delete();
    vbl_end();
    lines(2);
    vbl_start();
    check_load("after reset", 0, 0);

    // Write coincident with the vblank-rise detect is merged into the snapshot
    vbl_end();
    vblank = 1'b1;
    tick(1);
    cpu_write(1'b0, 8'h55);
    tick(10);
    check_load("merge", 1, 'h055);
    check("merge pending", int'(pending), 0);

    // Write during active display
    vbl_end();
    lines(2);
    cpu_write(1'b0, 8'h10);
    cpu_write(1'b1, 8'h00);
    c0 = n_ce;
    lines(1);
`ifdef VSCROLL_MIDFRAME_EN
    check("mid ce", n_ce - c0, 0);
    check_load("mid", 1, 'h010);
    check("mid pending", int'(pending), 0);
    c0 = n_ce;
    lines(2);
    check("mid resume ce", n_ce - c0, 2);
    vbl_start();
    check_load("mid vbl", 0, 0);
`else
    check("defer ce", n_ce - c0, 1);
    check_load("defer active", 0, 0);
    check("defer pending", int'(pending), 1);
    vbl_start();
    check_load("defer vbl", 1, 'h010);
`endif

    // Randomised frames against the model
    tc_rand = 1'b1;
    for (int f = 0; f < 20; f++) begin
      vbl_end();
      dir0 = int'(m_dir);
      c0 = n_ce; d0 = n_du1; t0 = n_tc; w0 = n_wrap;
      nl = int'($urandom_range(1, 6));
      lines(nl);
      nw = int'($urandom_range(0, 2));
      for (int k = 0; k < nw; k++) begin
        rd = 8'($urandom);
        cpu_write(1'($urandom_range(0, 1)), rd);
      end
      vbl_start();
      check("rnd ce count", n_ce - c0, nl);
      check("rnd du ones", n_du1 - d0, dir0 * nl);
      check("rnd wraps", n_wrap - w0, n_tc - t0);
      check_load("rnd", (nw > 0) ? 1 : 0, int'(m_sh));
      check("rnd pending", int'(pending), 0);
    end
    tc_rand = 1'b0;
    tick(2);

    check("ce pulse width errors", ce_err, 0);
    check("du stability errors", du_err, 0);
    check("wrap timing errors", wrap_err, 0);
    check("load value hold errors", ld_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
